bht_btb_predictor: RTL

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline, replacing static not-taken fetch with a direct-mapped branch target buffer holding N-bit saturating counters. IF looks it up with the fetch PC each cycle and gets a predicted next PC. ID, where beq/bne/j resolve, writes back the actual outcome. The block flags mispredictions so the hazard unit can flush IF/ID, and keeps branch and mispredict statistics.

---
 rtl/bht_btb_predictor_pkg.sv | 22 ++
 rtl/bht_btb_predictor_sat_counter.sv | 25 ++
 rtl/bht_btb_predictor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bht_btb_predictor_pkg.sv
// Shared defaults and helpers for the BHT/BTB branch predictor.
package bht_btb_predictor_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_ENTRIES  = 64;
  localparam int unsigned DEF_CTR_BITS = 2;
  localparam int unsigned DEF_STAT_W   = 32;

  // PC bits below the index field; instructions are word aligned.
  localparam int unsigned PC_IDX_LSB = 2;

  // Upper saturation limit of a counter of the given width.
  function automatic int unsigned ctr_max(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

  // Value loaded on allocation: weakly taken.
  function automatic int unsigned ctr_weak_taken(input int unsigned bits);
    return 1 << (bits - 1);
  endfunction

endpackage

// File: rtl/bht_btb_predictor_sat_counter.sv
// Saturating counter next-state logic: load wins, then increment, then decrement.
module sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] value,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] next
);

  // Next value, holding at all-ones on increment and at zero on decrement.
  always_comb begin
    next = value;
    if (load) begin
      next = load_val;
    end else if (inc && (value != {W{1'b1}})) begin
      next = value + W'(1);
    end else if (dec && (value != '0)) begin
      next = value - W'(1);
    end
  end

endmodule

// File: rtl/bht_btb_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, mispredict flag and statistics.
module bht_btb_predictor
  import bht_btb_predictor_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ENTRIES  = DEF_ENTRIES,
  parameter int unsigned CTR_BITS = DEF_CTR_BITS,
  parameter int unsigned STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_LSB = IDX_W + PC_IDX_LSB;
  localparam int unsigned TAG_W = ADDR_W - TAG_LSB;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                lk_hit, up_hit;
  logic [CTR_BITS-1:0] ctr_next;
  logic                tbl_we;

  // Field split of the lookup and update PCs.
  always_comb begin
    lk_idx = pc_if[TAG_LSB-1:PC_IDX_LSB];
    lk_tag = pc_if[ADDR_W-1:TAG_LSB];
    up_idx = upd_pc[TAG_LSB-1:PC_IDX_LSB];
    up_tag = upd_pc[ADDR_W-1:TAG_LSB];
    lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  // Zero-latency prediction from pre-update table contents.
  always_comb begin
    pred_taken   = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_next_pc = pred_taken ? target_q[lk_idx] : pc_if + ADDR_W'(4);
  end

  // Flush request when direction or taken target disagrees with the prediction.
  always_comb begin
    mispredict = upd_valid &&
                 ((upd_pred_taken != upd_taken) ||
                  (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));
  end

  sat_counter #(.W(CTR_BITS)) u_entry_ctr (
    .value    (ctr_q[up_idx]),
    .inc      (up_hit && upd_taken),
    .dec      (up_hit && !upd_taken),
    .load     (!up_hit && upd_taken),
    .load_val (CTR_BITS'(ctr_weak_taken(CTR_BITS))),
    .next     (ctr_next)
  );

  sat_counter #(.W(STAT_W)) u_branch_cnt (
    .value    (branch_cnt_q),
    .inc      (upd_valid),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({STAT_W{1'b0}}),
    .next     (branch_cnt_d)
  );

  sat_counter #(.W(STAT_W)) u_mispred_cnt (
    .value    (mispred_cnt_q),
    .inc      (mispredict),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({STAT_W{1'b0}}),
    .next     (mispred_cnt_d)
  );

  // A miss that was not taken leaves the table alone; reset drops the update.
  assign tbl_we = !rst && upd_valid && (up_hit || upd_taken);

  // Valid bits and statistics; the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_valid && upd_taken) begin
        valid_q[up_idx] <= 1'b1;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry payload; meaningless while the valid bit is clear, so never reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tag_q[up_idx] <= up_tag;
      ctr_q[up_idx] <= ctr_next;
      if (upd_taken) begin
        target_q[up_idx] <= upd_target;
      end
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
